// File: rtl/uart_rx_framer_pkg.sv
// Shared definitions for the UART receive framer: FSM states and the default oversampling ratio.
package uart_rx_framer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int unsigned RX_OSR = 8;

endpackage

// File: rtl/uart_rx_framer_fifo.sv
// Synchronous receive FIFO with a registered head output that holds its last value when drained.
module uart_rx_framer_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d, rptr_nx;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rptr_nx = rptr_q + 1'b1;
  assign dout_o  = dout_q;

  // The head register tracks whichever entry will be at rptr after this cycle.
  always_comb begin
    wptr_d = do_push ? (wptr_q + 1'b1) : wptr_q;
    rptr_d = do_pop ? rptr_nx : rptr_q;
    dout_d = dout_q;
    if (do_pop) begin
      if (rptr_nx != wptr_q) begin
        dout_d = mem_q[rptr_nx[AW-1:0]];
      end else if (do_push) begin
        dout_d = din_i;
      end
    end else if (do_push && empty_o) begin
      dout_d = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_q <= dout_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/uart_rx_framer.sv
// UART 8N1 receive framer: synchronises rxd, oversamples on bx8clk, checks framing and buffers bytes.
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OSR        = RX_OSR,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 bx8clk,
  input  logic                 rxd,
  input  logic                 rd_ackH,
  output logic [DATA_BITS-1:0] RDR,
  output logic                 rxd_readyH,
  output logic                 framing_errH,
  output logic                 overrun_errH,
  output logic                 rx_busyH
);

  localparam int unsigned TW = $clog2(OSR);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] MID_TICK  = TW'(OSR / 2 - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(OSR - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

  rx_state_e            state_q, state_d;
  logic                 rxd_meta_q, rxd_s_q;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [BW-1:0]        bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, oerr_q;
  logic                 stop_ok, stop_bad;
  logic                 fifo_empty, fifo_full;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      bcnt_q     <= '0;
      ferr_q     <= 1'b0;
      oerr_q     <= 1'b0;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      bcnt_q     <= bcnt_d;
      ferr_q     <= stop_bad;
      oerr_q     <= stop_ok & fifo_full & ~rd_ackH;
    end
  end

  always_ff @(posedge sysclk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    if (bx8clk) begin
      case (state_q)
        ST_IDLE:      if (!rxd_s_q) state_d = ST_START;
        ST_START:     if (tcnt_q == MID_TICK) state_d = rxd_s_q ? ST_IDLE : ST_DATA;
        ST_DATA:      if (tcnt_q == LAST_TICK && bcnt_q == LAST_BIT) state_d = ST_STOP;
        ST_STOP:      if (tcnt_q == LAST_TICK) state_d = rxd_s_q ? ST_IDLE : ST_WAIT_IDLE;
        ST_WAIT_IDLE: if (rxd_s_q) state_d = ST_IDLE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Counters, shift register and stop-bit verdict; all advance only on bx8clk.
  always_comb begin
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (bx8clk) begin
      case (state_q)
        ST_IDLE: begin
          tcnt_d = '0;
          bcnt_d = '0;
        end
        ST_START: begin
          if (tcnt_q == MID_TICK) begin
            tcnt_d = '0;
            bcnt_d = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == LAST_TICK) begin
            shift_d = {rxd_s_q, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 1'b1;
          end
        end
        ST_STOP: begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q == LAST_TICK) begin
            stop_ok  = rxd_s_q;
            stop_bad = ~rxd_s_q;
          end
        end
        default: ;
      endcase
    end
  end

  uart_rx_framer_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (sysclk),
    .rst_n_i (rst_n),
    .push_i  (stop_ok),
    .pop_i   (rd_ackH),
    .din_i   (shift_q),
    .dout_o  (RDR),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  assign rxd_readyH   = ~fifo_empty;
  assign framing_errH = ferr_q;
  assign overrun_errH = oerr_q;
  assign rx_busyH     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Self-checking bench for uart_rx_framer: directed frame table, multi-cycle corner sequences, random frames.
`timescale 1ns/1ps
module tb_uart_rx_framer;

  localparam int DB          = 8;
  localparam int DEPTH       = 4;
  localparam int FRAME_TICKS = 80;
  localparam int STOP_TICK   = 77;

  logic          sysclk  = 1'b0;
  logic          rst_n   = 1'b0;
  logic          bx8clk  = 1'b0;
  logic          rxd     = 1'b1;
  logic          rd_ackH = 1'b0;
  logic [DB-1:0] RDR;
  logic          rxd_readyH, framing_errH, overrun_errH, rx_busyH;

  int vectors     = 0;
  int miscompares = 0;
  int ferr_events = 0, oerr_events = 0, both_events = 0, wide_events = 0;
  int rise_tick;
  logic prev_ferr = 1'b0, prev_oerr = 1'b0;

  typedef struct {
    logic [7:0] data;
    logic       stopb;
    int         exp_ferr;
    logic       exp_ready;
    logic [7:0] exp_rdr;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] mq [$];
  logic [7:0] last_head;

  uart_rx_framer #(.DATA_BITS(DB), .OSR(8), .FIFO_DEPTH(DEPTH)) dut (
    .sysclk       (sysclk),
    .rst_n        (rst_n),
    .bx8clk       (bx8clk),
    .rxd          (rxd),
    .rd_ackH      (rd_ackH),
    .RDR          (RDR),
    .rxd_readyH   (rxd_readyH),
    .framing_errH (framing_errH),
    .overrun_errH (overrun_errH),
    .rx_busyH     (rx_busyH)
  );

  always #5 sysclk = ~sysclk;

  // Error-pulse event counters sampled just after each edge.
  always @(posedge sysclk) begin
    #1;
    if (framing_errH === 1'b1) ferr_events++;
    if (overrun_errH === 1'b1) oerr_events++;
    if (framing_errH === 1'b1 && overrun_errH === 1'b1) both_events++;
    if ((framing_errH === 1'b1 && prev_ferr === 1'b1) ||
        (overrun_errH === 1'b1 && prev_oerr === 1'b1)) wide_events++;
    prev_ferr = framing_errH;
    prev_oerr = overrun_errH;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input logic v);
    @(negedge sysclk);
    bx8clk = 1'b1;
    rxd    = v;
    @(negedge sysclk);
    bx8clk  = 1'b0;
    rd_ackH = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1);
  endtask

  // One 8N1 frame at 8 ticks per bit; optional rd_ackH on tick ack_tick; may be cut short.
  task automatic frame(input logic [7:0] b, input logic stopb, input int ack_tick, input int n_ticks);
    logic [9:0] bits;
    logic       was_ready;
    bits      = {stopb, b, 1'b0};
    rise_tick = -1;
    for (int t = 0; t < n_ticks; t++) begin
      was_ready = rxd_readyH;
      @(negedge sysclk);
      bx8clk  = 1'b1;
      rxd     = bits[t / 8];
      rd_ackH = (t == ack_tick);
      @(negedge sysclk);
      bx8clk  = 1'b0;
      rd_ackH = 1'b0;
      if (rise_tick < 0 && !was_ready && rxd_readyH) rise_tick = t;
    end
  endtask

  task automatic pop_cycle();
    @(negedge sysclk);
    rd_ackH = 1'b1;
    @(negedge sysclk);
    rd_ackH = 1'b0;
  endtask

  task automatic pop_expect(input string name, input logic [7:0] exp);
    check({name, "_ready"}, rxd_readyH, 1'b1);
    check({name, "_rdr"}, RDR, exp);
    pop_cycle();
  endtask

  initial begin
    int f0, o0, exp_f, exp_o, npop, gap;
    logic [7:0] b;
    logic stopb;

    tbl[0] = '{8'hA5, 1'b1, 0, 1'b1, 8'hA5};
    tbl[1] = '{8'h3C, 1'b0, 1, 1'b0, 8'hA5};
    tbl[2] = '{8'h00, 1'b1, 0, 1'b1, 8'h00};
    tbl[3] = '{8'hFF, 1'b1, 0, 1'b1, 8'hFF};
    tbl[4] = '{8'h81, 1'b0, 1, 1'b0, 8'hFF};
    tbl[5] = '{8'h5A, 1'b1, 0, 1'b1, 8'h5A};

    // Reset state
    repeat (3) @(negedge sysclk);
    check("rst_rdr", RDR, 8'h00);
    check("rst_ready", rxd_readyH, 1'b0);
    check("rst_ferr", framing_errH, 1'b0);
    check("rst_oerr", overrun_errH, 1'b0);
    check("rst_busy", rx_busyH, 1'b0);
    rst_n = 1'b1;
    idle(4);

    // Directed frame table
    for (int i = 0; i < 6; i++) begin
      f0 = ferr_events;
      o0 = oerr_events;
      frame(tbl[i].data, tbl[i].stopb, -1, FRAME_TICKS);
      if (tbl[i].exp_ready) check("tbl_rise_tick", rise_tick, STOP_TICK);
      idle(3);
      check("tbl_ferr", ferr_events - f0, tbl[i].exp_ferr);
      check("tbl_oerr", oerr_events - o0, 0);
      check("tbl_ready", rxd_readyH, tbl[i].exp_ready);
      check("tbl_rdr", RDR, tbl[i].exp_rdr);
      if (tbl[i].exp_ready) begin
        pop_cycle();
        check("tbl_empty_after_pop", rxd_readyH, 1'b0);
        check("tbl_rdr_hold", RDR, tbl[i].exp_rdr);
      end
    end

    // False start: two low ticks then high
    f0 = ferr_events;
    o0 = oerr_events;
    tick(1'b0);
    tick(1'b0);
    check("glitch_busy_high", rx_busyH, 1'b1);
    idle(10);
    check("glitch_busy_low", rx_busyH, 1'b0);
    check("glitch_ready", rxd_readyH, 1'b0);
    check("glitch_ferr", ferr_events - f0, 0);
    check("glitch_oerr", oerr_events - o0, 0);

    // Framing error followed by a break: must wait for rxd high
    f0 = ferr_events;
    frame(8'h3C, 1'b0, -1, FRAME_TICKS);
    for (int i = 0; i < 16; i++) tick(1'b0);
    check("break_ferr", ferr_events - f0, 1);
    check("break_ready", rxd_readyH, 1'b0);
    check("break_busy", rx_busyH, 1'b1);
    idle(3);
    check("break_release", rx_busyH, 1'b0);
    check("break_rdr_hold", RDR, 8'h5A);

    // Overrun: five frames with no reads
    f0 = ferr_events;
    o0 = oerr_events;
    for (int k = 1; k <= 5; k++) begin
      frame(8'(k), 1'b1, -1, FRAME_TICKS);
      idle(2);
      check("ovr_oerr", oerr_events - o0, (k == 5) ? 1 : 0);
      check("ovr_head", RDR, 8'h01);
    end
    check("ovr_ferr", ferr_events - f0, 0);

    // Full FIFO, read acknowledged on the push cycle of 0x77
    o0 = oerr_events;
    frame(8'h77, 1'b1, STOP_TICK, FRAME_TICKS);
    idle(2);
    check("fullpop_oerr", oerr_events - o0, 0);
    pop_expect("fullpop_2", 8'h02);
    pop_expect("fullpop_3", 8'h03);
    pop_expect("fullpop_4", 8'h04);
    pop_expect("fullpop_77", 8'h77);
    check("fullpop_empty", rxd_readyH, 1'b0);
    pop_cycle();
    check("empty_pop_ignored", rxd_readyH, 1'b0);
    check("empty_pop_rdr", RDR, 8'h77);

    // Reset in the middle of data bit 4
    frame(8'h96, 1'b1, -1, FRAME_TICKS);
    idle(2);
    check("prerst_ready", rxd_readyH, 1'b1);
    frame(8'hC3, 1'b1, -1, 44);
    check("prerst_busy", rx_busyH, 1'b1);
    @(negedge sysclk);
    rst_n = 1'b0;
    rxd   = 1'b1;
    @(negedge sysclk);
    check("midrst_busy", rx_busyH, 1'b0);
    check("midrst_ready", rxd_readyH, 1'b0);
    check("midrst_rdr", RDR, 8'h00);
    check("midrst_ferr", framing_errH, 1'b0);
    check("midrst_oerr", overrun_errH, 1'b0);
    rst_n = 1'b1;
    idle(4);
    f0 = ferr_events;
    frame(8'h5A, 1'b1, -1, FRAME_TICKS);
    idle(2);
    check("postrst_ferr", ferr_events - f0, 0);
    pop_expect("postrst", 8'h5A);
    last_head = 8'h5A;

    // Random frames against a byte-queue model of the link
    for (int n = 0; n < 40; n++) begin
      b     = 8'($urandom_range(0, 255));
      stopb = ($urandom_range(0, 9) != 0);
      gap   = $urandom_range(2, 5);
      f0    = ferr_events;
      o0    = oerr_events;
      exp_f = 0;
      exp_o = 0;
      frame(b, stopb, -1, FRAME_TICKS);
      idle(gap);
      if (!stopb) exp_f = 1;
      else if (mq.size() == DEPTH) exp_o = 1;
      else mq.push_back(b);
      check("rnd_ferr", ferr_events - f0, exp_f);
      check("rnd_oerr", oerr_events - o0, exp_o);
      check("rnd_ready", rxd_readyH, (mq.size() != 0));
      check("rnd_rdr", RDR, (mq.size() != 0) ? mq[0] : last_head);
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (mq.size() != 0) begin
          pop_expect("rnd_pop", mq[0]);
          last_head = mq.pop_front();
        end else begin
          pop_cycle();
          check("rnd_empty_pop", rxd_readyH, 1'b0);
        end
      end
    end

    check("never_both_errors", both_events, 0);
    check("pulses_one_cycle", wide_events, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
